// File: rtl/scratch_fill_ctrl_pkg.sv
// rtl/scratch_fill_ctrl_pkg.sv - shared FSM states and default widths for the scratchpad fill/check pair
package scratch_fill_ctrl_pkg;

  localparam int IF_CELL_SIZE_DEF        = 8;
  localparam int FILTER_CELL_SIZE_DEF    = 8;
  localparam int IF_ADDRESS_SIZE_DEF     = 8;
  localparam int FILTER_ADDRESS_SIZE_DEF = 8;
  localparam int CELL_NUMS_IF_DEF        = 8;
  localparam int CELL_NUMS_FILTER_DEF    = 8;
  localparam int LEN_SIZE_DEF            = 16;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LOAD_FILTER = 2'd1,
    STREAM_IF   = 2'd2,
    DONE        = 2'd3
  } fill_state_t;

endpackage

// File: rtl/scratch_fill_ctrl_circ_ptr.sv
// rtl/scratch_fill_ctrl_circ_ptr.sv - wrapping pointer with increment-enable and synchronous clear
module circ_ptr #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);

  logic [WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/scratch_fill_ctrl.sv
// rtl/scratch_fill_ctrl.sv - writes filter words linearly and IF words circularly into the PE scratchpads
module scratch_fill_ctrl
  import scratch_fill_ctrl_pkg::*;
#(
  parameter int IF_CELL_SIZE        = IF_CELL_SIZE_DEF,
  parameter int FILTER_CELL_SIZE    = FILTER_CELL_SIZE_DEF,
  parameter int IF_ADDRESS_SIZE     = IF_ADDRESS_SIZE_DEF,
  parameter int FILTER_ADDRESS_SIZE = FILTER_ADDRESS_SIZE_DEF,
  parameter int CELL_NUMS_IF        = CELL_NUMS_IF_DEF,
  parameter int CELL_NUMS_FILTER    = CELL_NUMS_FILTER_DEF,
  parameter int LEN_SIZE            = LEN_SIZE_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [FILTER_ADDRESS_SIZE:0] filter_len,
  input  logic [LEN_SIZE-1:0]          if_len,
  input  logic                         filter_valid,
  output logic                         filter_ready,
  input  logic [FILTER_CELL_SIZE-1:0]  filter_data,
  input  logic                         if_valid,
  output logic                         if_ready,
  input  logic [IF_CELL_SIZE-1:0]      if_data,
  input  logic                         if_release,
  output logic                         filter_wr_en,
  output logic [FILTER_ADDRESS_SIZE:0] filter_wr_addr,
  output logic [FILTER_CELL_SIZE-1:0]  filter_wr_data,
  output logic                         if_wr_en,
  output logic [IF_ADDRESS_SIZE:0]     if_wr_addr,
  output logic [IF_CELL_SIZE-1:0]      if_wr_data,
  output logic                         write_cnt_filter,
  output logic                         write_cnt_if,
  output logic [FILTER_ADDRESS_SIZE:0] write_addr_filter,
  output logic [IF_ADDRESS_SIZE:0]     write_addr_if,
  output logic [IF_ADDRESS_SIZE:0]     if_occupancy,
  output logic                         busy,
  output logic                         fill_done,
  output logic                         cfg_err
);

  localparam int FAW = FILTER_ADDRESS_SIZE + 1;
  localparam int IAW = IF_ADDRESS_SIZE + 1;
  localparam logic [FAW-1:0] FILTER_MAX = FAW'(CELL_NUMS_FILTER);
  localparam logic [IAW-1:0] IF_FULL    = IAW'(CELL_NUMS_IF);

  fill_state_t          state_q, state_d;
  logic [FAW-1:0]       filter_len_q, filter_len_d;
  logic [LEN_SIZE-1:0]  if_len_q, if_len_d;
  logic [LEN_SIZE-1:0]  if_cnt_q, if_cnt_d;
  logic [IAW-1:0]       occ_q, occ_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 fill_done_q, fill_done_d;

  logic           cfg_ok, start_ok, rel_ok;
  logic [FAW-1:0] filter_ptr;
  logic [IAW-1:0] if_ptr;

  // Ready is a function of registered state only, so release cannot bypass into the same cycle.
  assign filter_ready = (state_q == LOAD_FILTER);
  assign if_ready     = (state_q == STREAM_IF) && (occ_q < IF_FULL);
  assign filter_wr_en = filter_valid & filter_ready;
  assign if_wr_en     = if_valid & if_ready;

  assign cfg_ok   = (filter_len != '0) && (filter_len <= FILTER_MAX) && (if_len != '0);
  assign start_ok = (state_q == IDLE) && start && cfg_ok;
  assign rel_ok   = if_release && (occ_q != '0);

  // Filter depth is the full pointer range, so a legal load never reaches the wrap point.
  circ_ptr #(.WIDTH(FAW), .DEPTH(1 << FAW)) u_filter_ptr (
    .clk(clk), .rst_n(rst), .clr(start_ok), .inc(filter_wr_en), .ptr(filter_ptr)
  );

  circ_ptr #(.WIDTH(IAW), .DEPTH(CELL_NUMS_IF)) u_if_ptr (
    .clk(clk), .rst_n(rst), .clr(start_ok), .inc(if_wr_en), .ptr(if_ptr)
  );

  always_comb begin
    state_d      = state_q;
    filter_len_d = filter_len_q;
    if_len_d     = if_len_q;
    if_cnt_d     = if_cnt_q;
    occ_d        = occ_q;
    cfg_err_d    = cfg_err_q;
    fill_done_d  = (state_q == DONE);

    if (if_release && (occ_q == '0)) cfg_err_d = 1'b1;
    if (if_wr_en && !rel_ok)      occ_d = occ_q + IAW'(1);
    else if (!if_wr_en && rel_ok) occ_d = occ_q - IAW'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            filter_len_d = filter_len;
            if_len_d     = if_len;
            if_cnt_d     = '0;
            occ_d        = '0;
            cfg_err_d    = 1'b0;
            state_d      = LOAD_FILTER;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      LOAD_FILTER: begin
        if (filter_wr_en && (filter_ptr == filter_len_q - FAW'(1))) state_d = STREAM_IF;
      end
      STREAM_IF: begin
        if (if_wr_en) begin
          if_cnt_d = if_cnt_q + LEN_SIZE'(1);
          if (if_cnt_q == if_len_q - LEN_SIZE'(1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      filter_len_q <= '0;
      if_len_q     <= '0;
      if_cnt_q     <= '0;
      occ_q        <= '0;
      cfg_err_q    <= 1'b0;
      fill_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      filter_len_q <= filter_len_d;
      if_len_q     <= if_len_d;
      if_cnt_q     <= if_cnt_d;
      occ_q        <= occ_d;
      cfg_err_q    <= cfg_err_d;
      fill_done_q  <= fill_done_d;
    end
  end

  // Data is gated by the strobe so the write port reads all-zero whenever nothing is written.
  assign filter_wr_data    = filter_wr_en ? filter_data : '0;
  assign if_wr_data        = if_wr_en ? if_data : '0;
  assign filter_wr_addr    = filter_ptr;
  assign if_wr_addr        = if_ptr;
  assign write_addr_filter = filter_ptr;
  assign write_addr_if     = if_ptr;
  assign write_cnt_filter  = filter_wr_en;
  assign write_cnt_if      = if_wr_en;
  assign if_occupancy      = occ_q;
  assign busy              = (state_q != IDLE);
  assign fill_done         = fill_done_q;
  assign cfg_err           = cfg_err_q;

endmodule

// File: tb/tb_scratch_fill_ctrl.sv
// tb/tb_scratch_fill_ctrl.sv - directed self-checking bench for scratch_fill_ctrl
module tb_scratch_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [8:0]  filter_len;
  logic [15:0] if_len;
  logic        filter_valid, filter_ready;
  logic [7:0]  filter_data;
  logic        if_valid, if_ready;
  logic [7:0]  if_data;
  logic        if_release;
  logic        filter_wr_en, if_wr_en;
  logic [8:0]  filter_wr_addr, if_wr_addr;
  logic [7:0]  filter_wr_data, if_wr_data;
  logic        write_cnt_filter, write_cnt_if;
  logic [8:0]  write_addr_filter, write_addr_if, if_occupancy;
  logic        busy, fill_done, cfg_err;

  int checks = 0;
  int errors = 0;

  scratch_fill_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .filter_len(filter_len), .if_len(if_len),
    .filter_valid(filter_valid), .filter_ready(filter_ready), .filter_data(filter_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_data(if_data), .if_release(if_release),
    .filter_wr_en(filter_wr_en), .filter_wr_addr(filter_wr_addr), .filter_wr_data(filter_wr_data),
    .if_wr_en(if_wr_en), .if_wr_addr(if_wr_addr), .if_wr_data(if_wr_data),
    .write_cnt_filter(write_cnt_filter), .write_cnt_if(write_cnt_if),
    .write_addr_filter(write_addr_filter), .write_addr_if(write_addr_if),
    .if_occupancy(if_occupancy), .busy(busy), .fill_done(fill_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int fexp, iexp, icnt, done_cyc, ndone, nwr, found;
    logic prev;

    rst = 1'b0; start = 1'b0; filter_len = '0; if_len = '0;
    filter_valid = 1'b0; filter_data = '0; if_valid = 1'b0; if_data = '0; if_release = 1'b0;
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_occ", 32'(if_occupancy), 0);
    chk("rst_waddr_if", 32'(write_addr_if), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    rst = 1'b1;
    step();

    // Load with consumer releasing each IF cell one cycle after it is written
    filter_valid = 1'b1; if_valid = 1'b1;
    filter_len = 9'd4; if_len = 16'd6; start = 1'b1;
    step();
    start = 1'b0;
    prev = 1'b0; fexp = 0; iexp = 0; icnt = 0; done_cyc = -1; ndone = 0;
    for (int c = 1; c <= 14; c++) begin
      if_release  = prev;
      filter_data = 8'(8'h10 + c);
      if_data     = 8'(8'h80 + c);
      #1;
      if (filter_wr_en) begin
        chk("t1_faddr", 32'(filter_wr_addr), fexp);
        chk("t1_fdata", 32'(filter_wr_data), 32'(8'(8'h10 + c)));
        fexp++;
      end
      if (if_wr_en) begin
        chk("t1_iaddr", 32'(if_wr_addr), iexp);
        chk("t1_idata", 32'(if_wr_data), 32'(8'(8'h80 + c)));
        iexp++;
      end
      if (write_cnt_if) icnt++;
      if (fill_done) begin done_cyc = c; ndone++; end
      prev = if_wr_en;
      step();
    end
    if_release = 1'b0;
    chk("t1_fwrites", 32'(fexp), 4);
    chk("t1_iwrites", 32'(iexp), 6);
    chk("t1_cnt_if", 32'(icnt), 6);
    chk("t1_done_cyc", 32'(done_cyc), 12);
    chk("t1_done_n", 32'(ndone), 1);
    chk("t1_occ", 32'(if_occupancy), 0);
    chk("t1_busy", 32'(busy), 0);

    // Bad configurations: no load starts, no writes, sticky error
    filter_len = 9'd0; if_len = 16'd5; start = 1'b1;
    step(); start = 1'b0; #1;
    chk("bad0_err", 32'(cfg_err), 1);
    chk("bad0_busy", 32'(busy), 0);
    chk("bad0_wr", 32'(filter_wr_en), 0);
    filter_len = 9'd9; start = 1'b1;
    step(); start = 1'b0; #1;
    chk("bad9_err", 32'(cfg_err), 1);
    chk("bad9_busy", 32'(busy), 0);
    chk("bad9_cnt", 32'(write_cnt_filter), 0);
    filter_len = 9'd8; if_len = 16'd0; start = 1'b1;
    step(); start = 1'b0; #1;
    chk("badlen_err", 32'(cfg_err), 1);
    chk("badlen_busy", 32'(busy), 0);

    // Full stall: 10 IF words into 8 cells without releases
    filter_len = 9'd1; if_len = 16'd10; start = 1'b1;
    step(); start = 1'b0; #1;
    chk("t2_err_clr", 32'(cfg_err), 0);
    chk("t2_busy", 32'(busy), 1);
    nwr = 0;
    for (int c = 0; c < 40 && nwr < 8; c++) begin
      if (if_wr_en) begin
        chk("t2_iaddr", 32'(if_wr_addr), nwr);
        nwr++;
      end
      step(); #1;
    end
    chk("t2_nwr", 32'(nwr), 8);
    chk("t2_occ_full", 32'(if_occupancy), 8);
    chk("t2_ready_full", 32'(if_ready), 0);
    chk("t2_wr_full", 32'(if_wr_en), 0);
    step(); #1;
    chk("t2_ready_hold", 32'(if_ready), 0);
    if_release = 1'b1; #1;
    chk("t2_no_bypass", 32'(if_ready), 0);
    step(); if_release = 1'b0; #1;
    chk("t2_occ_rel", 32'(if_occupancy), 7);
    chk("t2_ready_up", 32'(if_ready), 1);
    chk("t2_wr9", 32'(if_wr_en), 1);
    chk("t2_wrap_addr", 32'(if_wr_addr), 0);
    step(); #1;
    chk("t2_occ_refull", 32'(if_occupancy), 8);
    chk("t2_ready_refull", 32'(if_ready), 0);
    if_release = 1'b1;
    step(); if_release = 1'b0; #1;
    chk("t2_wr10_addr", 32'(if_wr_addr), 1);
    chk("t2_wr10", 32'(if_wr_en), 1);
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      step(); #1;
      if (fill_done) found = 1;
    end
    chk("t2_done", 32'(found), 1);
    chk("t2_occ_end", 32'(if_occupancy), 8);

    // Simultaneous write and release at occupancy 5
    filter_len = 9'd1; if_len = 16'd8; start = 1'b1;
    step(); start = 1'b0; #1;
    chk("t3_occ_start", 32'(if_occupancy), 0);
    for (int c = 0; c < 20 && if_occupancy != 9'd5; c++) begin
      step(); #1;
    end
    chk("t3_occ5", 32'(if_occupancy), 5);
    if_release = 1'b1; #1;
    chk("t3_wr_same", 32'(if_wr_en), 1);
    step(); if_release = 1'b0; #1;
    chk("t3_occ_same", 32'(if_occupancy), 5);
    for (int c = 0; c < 30 && busy; c++) begin
      step(); #1;
    end
    chk("t3_busy_end", 32'(busy), 0);
    chk("t3_occ_end", 32'(if_occupancy), 7);

    // Drain after DONE, then underflow
    if_release = 1'b1;
    for (int c = 0; c < 7; c++) step();
    if_release = 1'b0; #1;
    chk("drain_occ", 32'(if_occupancy), 0);
    chk("drain_err", 32'(cfg_err), 0);
    if_release = 1'b1;
    step(); if_release = 1'b0; #1;
    chk("uflow_occ", 32'(if_occupancy), 0);
    chk("uflow_err", 32'(cfg_err), 1);

    // Reset during STREAM_IF
    filter_len = 9'd1; if_len = 16'd6; start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step(); #1;
    chk("t5_pre_busy", 32'(busy), 1);
    chk("t5_pre_occ", 32'(if_occupancy), 2);
    rst = 1'b0; #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_if_ready", 32'(if_ready), 0);
    chk("t5_if_wr", 32'(if_wr_en), 0);
    chk("t5_cnt_if", 32'(write_cnt_if), 0);
    chk("t5_waddr_if", 32'(write_addr_if), 0);
    chk("t5_occ", 32'(if_occupancy), 0);
    chk("t5_fready", 32'(filter_ready), 0);
    chk("t5_fill_done", 32'(fill_done), 0);
    chk("t5_cfg_err", 32'(cfg_err), 0);
    step();
    rst = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      step(); #1;
      if (fill_done) ndone++;
    end
    chk("t5_no_done", 32'(ndone), 0);
    chk("t5_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scratch_fill_ctrl.md
# scratch_fill_ctrl

Write-side controller for the convolution PE's IF and filter scratchpads; it is the producer that the scratchpad checker consumes from. It accepts filter and IF words over valid/ready channels and writes them into the scratchpads: filter linearly from address 0, IF circularly. It drives the write strobes, addresses and count pulses that the checker tracks, and applies IF back-pressure from occupancy, which is decremented by release pulses returned by the read side.

## Interface
- IF_CELL_SIZE, 8, IF word width
- FILTER_CELL_SIZE, 8, filter word width
- IF_ADDRESS_SIZE, 8, IF address/occupancy vector is [IF_ADDRESS_SIZE:0]
- FILTER_ADDRESS_SIZE, 8, filter address vector is [FILTER_ADDRESS_SIZE:0]
- CELL_NUMS_IF, 8, IF scratchpad depth (cells)
- CELL_NUMS_FILTER, 8, filter scratchpad depth (cells)
- LEN_SIZE, 16, width of the IF stream length
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  pulse, begins a layer load; honoured only in IDLE
- filter_len  in  FILTER_ADDRESS_SIZE+1  filter words to load
- if_len  in  LEN_SIZE  IF words to stream
- filter_valid / filter_ready  in / out  1  filter channel handshake
- filter_data  in  FILTER_CELL_SIZE  filter word
- if_valid / if_ready  in / out  1  IF channel handshake
- if_data  in  IF_CELL_SIZE  IF word
- if_release  in  1  pulse, read side freed one IF cell
- filter_wr_en, filter_wr_addr[FILTER_ADDRESS_SIZE:0], filter_wr_data  out  filter scratchpad write port
- if_wr_en, if_wr_addr[IF_ADDRESS_SIZE:0], if_wr_data  out  IF scratchpad write port
- write_cnt_filter / write_cnt_if  out  1  one pulse per word written
- write_addr_filter / write_addr_if  out  address vectors  registered next-free-cell pointer
- if_occupancy  out  IF_ADDRESS_SIZE+1  cells holding unconsumed data
- busy  out  1  high outside IDLE
- fill_done  out  1  one-cycle pulse, load complete
- cfg_err  out  1  sticky bad config / underflow flag, cleared by the next accepted start

## Operation
- FSM: IDLE -> LOAD_FILTER -> STREAM_IF -> DONE -> IDLE.
- IDLE: start with 1 <= filter_len <= CELL_NUMS_FILTER and if_len != 0 latches the lengths, clears pointers and occupancy, clears cfg_err, and enters LOAD_FILTER. Any other start sets cfg_err and remains in IDLE.
- LOAD_FILTER: filter_ready = 1. Each handshake writes to filter_wr_addr = write_addr_filter and then increments the pointer. After the filter_len-th write, move to STREAM_IF.
- STREAM_IF: if_ready = (if_occupancy < CELL_NUMS_IF). Each handshake writes to write_addr_if; the pointer wraps from CELL_NUMS_IF-1 to 0. After the if_len-th write, move to DONE.
- DONE: assert fill_done for one cycle, then go to IDLE.
- Occupancy: a write alone increments it; a release alone decrements it; a write and a release in the same cycle leave it unchanged. A release at occupancy 0 is ignored and sets cfg_err.
- if_release is honoured in every state, so the IF buffer drains after DONE. start resets occupancy to 0.
- start outside IDLE is ignored.

## Timing
- filter_wr_en = filter_valid & filter_ready; if_wr_en = if_valid & if_ready. Both are combinational, so the write occurs in the handshake cycle.
- wr_data passes through combinationally; wr_addr equals the registered pointer.
- write_cnt_* equal wr_en (same cycle). Pointers and occupancy update on the following edge.
- Ready signals depend only on registered state, never on valid.
- Full-to-not-full: a release at occupancy = CELL_NUMS_IF raises if_ready on the next cycle (no same-cycle bypass).
- Reset values: all outputs 0, state IDLE, pointers 0, occupancy 0.
- Reset asserted mid-load aborts immediately. No fill_done pulse is issued for the aborted load.
- Throughput: one word per cycle per active channel. Minimum time from start to fill_done is filter_len + if_len + 2 cycles.

## Structure
- Shared package: FSM state enum (IDLE, LOAD_FILTER, STREAM_IF, DONE) and default width constants common to the checker and this block.
- One sub-module, circ_ptr: a wrapping pointer with increment-enable, clear and depth parameter. It is instantiated for the IF pointer; the filter pointer uses it with a depth that never wraps.

## Test plan
- Load, no back-pressure: filter_len=4, if_len=6, consumer releases each cell the cycle after it is written. Expect filter writes at addresses 0..3, IF writes at 0..5, six write_cnt_if pulses, and fill_done at cycle 12 after start.
- Full stall: CELL_NUMS_IF=8, if_len=10, no releases. Expect if_ready low after 8 writes (occupancy 8). One release then re-raises if_ready the next cycle, and the 9th word is written to address 0 (wrap).
- Simultaneous events: a write and a release in the same cycle at occupancy 5. Expect occupancy to stay 5.
- Bad config: start with filter_len=0, then with filter_len=9. Expect cfg_err=1, busy=0, and no writes. A following valid start clears cfg_err.
- Underflow: if_release at occupancy 0. Expect occupancy to stay 0 and cfg_err=1.
- Reset mid-stream: rst low during STREAM_IF. Expect all outputs 0 immediately, state IDLE, and no fill_done pulse.
